mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port RAM between two requesters:
//   - the CPU datapath (MAR/MDR path, driven by the control unit);
//   - the boot/DMA loader.
//  Grants one request at a time, using round-robin priority.
//  Sequences the RAM read/write strobes and hides the RAM read latency behind a req/ack handshake.
//  Sits between the requesters and the RAM's read/write/addr/data pins.
// PARAMETERS
//  ADDR_W  9   RAM address width
//  DATA_W  32  data word width
//  RD_LAT  2   RAM read latency in cycles (legal range 1..15)
// PORTS
//  clock      in   1       system clock; all state updates on the rising edge
//  reset      in   1       asynchronous, active-low reset
//  init_lock  in   1       1 = loader-only mode; CPU requests are not granted
//  cpu_req    in   1       CPU request; hold high until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_ack    out  1       one-cycle completion pulse to the CPU
//  cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack, then held
//  ld_req     in   1       loader request; hold high until ld_ack
//  ld_we      in   1       1 = write, 0 = read
//  ld_addr    in   ADDR_W  loader address
//  ld_wdata   in   DATA_W  loader write data
//  ld_ack     out  1       one-cycle completion pulse to the loader
//  ld_rdata   out  DATA_W  loader read data; valid with ld_ack, then held
//  ram_read   out  1       RAM read strobe
//  ram_write  out  1       RAM write strobe
//  ram_addr   out  ADDR_W  RAM address (registered)
//  ram_wdata  out  DATA_W  RAM write data (registered)
//  ram_rdata  in   DATA_W  RAM read data
//  busy       out  1       1 whenever state != IDLE
//  grant_id   out  1       owner of the current transaction: 0 = CPU, 1 = loader
// BEHAVIOUR
//  Reset values (reset low, asynchronous):
//   - state = IDLE; every output = 0;
//   - last_grant = loader, so the CPU wins the first tie.
//  States:
//   - IDLE: samples requests on each edge.
//   - ACCESS: strobe asserted.
//   - WAIT: reads only; holds ram_read.
//   - DONE: ack pulse for one cycle, then back to IDLE.
//  Arbitration (IDLE only):
//   - eligible = {ld_req, cpu_req & ~init_lock};
//   - one eligible request: grant it;
//   - both eligible: grant the requester that is not last_grant;
//   - on a grant: latch we, addr and wdata of the winner into ram_addr/ram_wdata; set grant_id and last_grant.
//  Write transaction:
//   - ACCESS lasts 1 cycle with ram_write = 1, then DONE.
//   - Request sampled at edge E: ram_write is high in cycle E+1; ack is high in cycle E+2.
//  Read transaction:
//   - ram_read = 1 for exactly RD_LAT cycles: ACCESS, then WAIT for RD_LAT-1 cycles.
//   - WAIT counts with a 4-bit counter.
//   - ram_rdata is captured into the owner's rdata register on the last edge of that window.
//   - DONE asserts the owner's ack.
//   - With RD_LAT = 2 and request sampled at E: ram_read is high in cycles E+1..E+2; ack is high in E+3.
//  Invariants:
//   - ram_read and ram_write are never high together;
//   - at most one ack is high in any cycle;
//   - ram_addr/ram_wdata stay stable for the whole transaction.
//  Handshake rules:
//   - Requests are only looked at in IDLE.
//   - A request dropped before its grant is lost silently.
//   - Input changes after the grant have no effect on the current transaction.
//   - A req still high in the cycle after ack starts a new transaction, re-arbitrated in IDLE.
//   - Back-to-back throughput: one write every 3 cycles per port.
//  init_lock:
//   - Raising it mid-transaction does not abort the transaction; it only gates new CPU grants.
//   - While locked, cpu_req stalls indefinitely and cpu_ack stays 0.
//  rdata:
//   - Each rdata register changes only on a read completion for its own port.
//   - A write leaves rdata unchanged.
//  Reset mid-transaction: strobes and ack drop immediately; the transaction is discarded.
// TESTING
//  1. CPU write, addr 0x012, data 0xDEADBEEF:
//     ram_write high exactly 1 cycle with addr 0x012 -> cpu_ack in cycle E+2.
//  2. CPU read of 0x012 with RD_LAT=2:
//     ram_read high 2 cycles -> cpu_ack in E+3 with cpu_rdata = 0xDEADBEEF.
//  3. cpu_req and ld_req rise together and are held high:
//     grant order CPU, LD, CPU, LD; grant_id alternates; acks never overlap.
//  4. init_lock = 1, both requesting:
//     only ld_ack pulses; drop init_lock -> next IDLE grants the CPU.
//  5. Assert reset while ram_read is high:
//     all outputs 0 asynchronously; after release, busy = 0 and the first tie goes to the CPU.
//  6. Loader writes 0x1FF = 0x5, then the CPU reads 0x1FF:
//     cpu_rdata = 0x5; ld_rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing a single-port RAM between the CPU and the loader,
// sequencing the read/write strobes and hiding read latency behind a req/ack handshake.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_lock,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_ld_req,
    input  logic              i_ld_we,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic              o_ld_ack,
    output logic [DATA_W-1:0] o_ld_rdata,
    output logic              o_ram_read,
    output logic              o_ram_write,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy,
    output logic              o_grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic              r_we, r_last, r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_cpu_rdata, r_ld_rdata;
    logic [1:0]        w_elig;
    logic              w_any, w_pick_ld, w_last_rd, w_grant;

    assign w_elig    = {i_ld_req, i_cpu_req & ~i_init_lock};
    assign w_any     = |w_elig;
    // On a tie the loader wins only if the CPU was served last.
    assign w_pick_ld = w_elig[1] & (~w_elig[0] | ~r_last);
    assign w_grant   = (r_state == IDLE) && w_any;
    assign w_last_rd = ~r_we & (((r_state == ACCESS) && (RD_LAT == 1)) ||
                                ((r_state == WAIT) && (r_cnt == 4'(RD_LAT - 1))));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = (r_we || RD_LAT == 1) ? DONE : WAIT;
            WAIT:    w_next = w_last_rd ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= 4'd1;
            r_we        <= 1'b0;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_we    <= w_pick_ld ? i_ld_we    : i_cpu_we;
                r_addr  <= w_pick_ld ? i_ld_addr  : i_cpu_addr;
                r_wdata <= w_pick_ld ? i_ld_wdata : i_cpu_wdata;
                r_grant <= w_pick_ld;
                r_last  <= w_pick_ld;
            end
            r_cnt <= (r_state == WAIT) ? r_cnt + 4'd1 : 4'd1;
            if (w_last_rd && !r_grant) r_cpu_rdata <= i_ram_rdata;
            if (w_last_rd && r_grant)  r_ld_rdata  <= i_ram_rdata;
        end
    end

    // Strobes and acks decode straight from state so reset drops them immediately.
    assign o_ram_write = (r_state == ACCESS) && r_we;
    assign o_ram_read  = ((r_state == ACCESS) && !r_we) || (r_state == WAIT);
    assign o_cpu_ack   = (r_state == DONE) && !r_grant;
    assign o_ld_ack    = (r_state == DONE) && r_grant;
    assign o_busy      = r_state != IDLE;
    assign o_grant_id  = r_grant;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_ld_rdata  = r_ld_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written sequences for round-robin,
// init_lock and asynchronous reset behaviour of mem_port_arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, lock = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
    logic [8:0]  cpu_addr = '0, ld_addr = '0, ram_addr;
    logic [31:0] cpu_wdata = '0, ld_wdata = '0, cpu_rdata, ld_rdata, ram_wdata, ram_rdata;
    logic        cpu_ack, ld_ack, ram_read, ram_write, busy, grant_id;
    logic [31:0] mem [512];
    logic [31:0] m_cpu = '0, m_ld = '0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_init_lock(lock),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
        .o_ld_ack(ld_ack), .o_ld_rdata(ld_rdata),
        .o_ram_read(ram_read), .o_ram_write(ram_write), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
        .o_busy(busy), .o_grant_id(grant_id)
    );

    always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    typedef struct {
        logic        none;
        logic        lock;
        logic        creq, cwe;
        logic [8:0]  caddr;
        logic [31:0] cwd;
        logic        lreq, lwe;
        logic [8:0]  laddr;
        logic [31:0] lwd;
        logic        gid;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_read"}, ram_read, 0);
        chk({tag, "_write"}, ram_write, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_ld_ack"}, ld_ack, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_wdata"}, ram_wdata, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_ld_rdata"}, ld_rdata, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wd;
        int          lat;
        @(negedge clk);
        lock = v.lock;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        ld_req = v.lreq;  ld_we = v.lwe;  ld_addr = v.laddr;  ld_wdata = v.lwd;
        if (v.none) begin
            repeat (5) begin
                @(negedge clk);
                chk($sformatf("v%0d_locked_busy", idx), busy, 0);
                chk($sformatf("v%0d_locked_cpu_ack", idx), cpu_ack, 0);
            end
            cpu_req = 0; ld_req = 0;
            return;
        end
        we   = v.gid ? v.lwe : v.cwe;
        addr = v.gid ? v.laddr : v.caddr;
        wd   = v.gid ? v.lwd : v.cwd;
        lat  = we ? 2 : 3;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_k%0d_write", idx, k), ram_write, we && k < lat);
            chk($sformatf("v%0d_k%0d_read", idx, k), ram_read, !we && k < lat);
            chk($sformatf("v%0d_k%0d_cpu_ack", idx, k), cpu_ack, k == lat && !v.gid);
            chk($sformatf("v%0d_k%0d_ld_ack", idx, k), ld_ack, k == lat && v.gid);
            chk($sformatf("v%0d_k%0d_busy", idx, k), busy, 1);
            chk($sformatf("v%0d_k%0d_gid", idx, k), grant_id, v.gid);
            chk($sformatf("v%0d_k%0d_addr", idx, k), ram_addr, addr);
            if (we) chk($sformatf("v%0d_k%0d_wdata", idx, k), ram_wdata, wd);
        end
        cpu_req = 0; ld_req = 0;
        if (!we && !v.gid) m_cpu = v.rd;
        if (!we && v.gid)  m_ld  = v.rd;
        chk($sformatf("v%0d_cpu_rdata", idx), cpu_rdata, m_cpu);
        chk($sformatf("v%0d_ld_rdata", idx), ld_rdata, m_ld);
        @(negedge clk);
        chk($sformatf("v%0d_idle_busy", idx), busy, 0);
    endtask

    initial begin
        int   got [4];
        int   ack_t [4];
        int   na;
        logic seen;
        vecs[0] = '{0, 0, 1, 1, 9'h012, 32'hDEADBEEF, 0, 0, 9'h000, 32'h0,        0, 32'h0};
        vecs[1] = '{0, 0, 1, 0, 9'h012, 32'h0,        0, 0, 9'h000, 32'h0,        0, 32'hDEADBEEF};
        vecs[2] = '{0, 0, 1, 1, 9'h020, 32'h11111111, 1, 1, 9'h021, 32'h22222222, 1, 32'h0};
        vecs[3] = '{0, 0, 1, 1, 9'h020, 32'h11111111, 1, 1, 9'h021, 32'h22222222, 0, 32'h0};
        vecs[4] = '{0, 1, 1, 0, 9'h012, 32'h0,        1, 0, 9'h021, 32'h0,        1, 32'h22222222};
        vecs[5] = '{1, 1, 1, 0, 9'h012, 32'h0,        0, 0, 9'h000, 32'h0,        0, 32'h0};
        vecs[6] = '{0, 0, 0, 0, 9'h000, 32'h0,        1, 1, 9'h1FF, 32'h5,        1, 32'h0};
        vecs[7] = '{0, 0, 1, 0, 9'h1FF, 32'h0,        0, 0, 9'h000, 32'h0,        0, 32'h5};
        vecs[8] = '{0, 0, 0, 0, 9'h000, 32'h0,        1, 0, 9'h020, 32'h0,        1, 32'h11111111};

        #2 check_all_zero("reset");
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Both requesters held high: grants alternate, one write every 3 cycles.
        @(negedge clk);
        lock = 0;
        cpu_we = 1; cpu_addr = 9'h030; cpu_wdata = 32'hAAAA0001;
        ld_we = 1;  ld_addr = 9'h031;  ld_wdata = 32'hBBBB0002;
        cpu_req = 1; ld_req = 1;
        na = 0;
        for (int c = 0; c < 40 && na < 4; c++) begin
            @(negedge clk);
            chk("rr_ack_overlap", {31'b0, cpu_ack & ld_ack}, 0);
            chk("rr_strobe_overlap", {31'b0, ram_read & ram_write}, 0);
            if (cpu_ack | ld_ack) begin
                got[na] = int'(ld_ack);
                ack_t[na] = c;
                chk("rr_gid", grant_id, ld_ack);
                na++;
                if (na == 4) begin cpu_req = 0; ld_req = 0; end
            end
        end
        chk("rr_count", na, 4);
        for (int i = 0; i < na; i++) begin
            chk($sformatf("rr_order%0d", i), got[i], i % 2);
            if (i > 0) chk($sformatf("rr_gap%0d", i), ack_t[i] - ack_t[i-1], 3);
        end
        @(negedge clk);
        chk("rr_idle_busy", busy, 0);

        // Locked: only the loader is served; unlocking lets the CPU win the next tie.
        lock = 1;
        cpu_we = 1; cpu_addr = 9'h040; cpu_wdata = 32'h40;
        ld_we = 1;  ld_addr = 9'h041;  ld_wdata = 32'h41;
        cpu_req = 1; ld_req = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            chk("lock_no_cpu_ack", cpu_ack, 0);
            if (ld_ack) seen = 1;
        end
        chk("lock_ld_ack_seen", seen, 1);
        lock = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cpu_ack | ld_ack) begin
                seen = 1;
                chk("unlock_cpu_first", cpu_ack, 1);
                chk("unlock_gid", grant_id, 0);
            end
        end
        chk("unlock_ack_seen", seen, 1);
        cpu_req = 0; ld_req = 0;
        @(negedge clk);
        chk("unlock_idle_busy", busy, 0);

        // Asynchronous reset while a CPU read has ram_read high.
        cpu_we = 0; cpu_addr = 9'h012; cpu_req = 1;
        @(negedge clk);
        chk("rst_pre_read", ram_read, 1);
        #2 rst_n = 0;
        #1 check_all_zero("async_rst");
        cpu_req = 0;
        @(negedge clk) rst_n = 1;
        m_cpu = 0; m_ld = 0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        cpu_we = 1; cpu_addr = 9'h050; cpu_wdata = 32'h50;
        ld_we = 1;  ld_addr = 9'h051;  ld_wdata = 32'h51;
        cpu_req = 1; ld_req = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cpu_ack | ld_ack) begin
                seen = 1;
                chk("post_rst_cpu_first", cpu_ack, 1);
                chk("post_rst_gid", grant_id, 0);
            end
        end
        chk("post_rst_ack_seen", seen, 1);
        cpu_req = 0; ld_req = 0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
